// File: rtl/display_timing_pkg.sv
// Shared raster timing constants (640x480@60 defaults) and axis helpers.
// The gfx-side blocks import this package for H_ACTIVE/V_ACTIVE.
package display_timing_pkg;

  typedef logic [15:0] pos_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Total period of one axis: visible + front porch + sync + back porch.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/display_timing_axis.sv
// One raster axis: wrapping position counter with registered sync decode.
// Also exposes the active decode of the next position so the top can
// register data-enable in step with both axes.
module timing_axis
  import display_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,          // register update strobe
  input  logic        inc_i,         // step position when updating
  output logic [15:0] pos_o,
  output logic        last_o,        // position is TOTAL-1, next step wraps
  output logic        active_nxt_o,  // next position lies in the visible span
  output logic        sync_o
);

  localparam int   TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam pos_t LAST     = pos_t'(TOTAL - 1);
  localparam pos_t ACT_END  = pos_t'(ACTIVE);
  localparam pos_t SYNC_BEG = pos_t'(ACTIVE + FP);
  localparam pos_t SYNC_END = pos_t'(ACTIVE + FP + SYNC);

  pos_t pos_q, pos_d;
  logic sync_q, sync_d;

  assign last_o = (pos_q == LAST);
  assign pos_o  = pos_q;
  assign sync_o = sync_q;

  // Next position and its decode; sync is driven at POL inside the sync span.
  always_comb begin
    pos_d = pos_q;
    if (inc_i) begin
      pos_d = last_o ? '0 : pos_q + 16'd1;
    end
    active_nxt_o = (pos_d < ACT_END);
    sync_d       = ((pos_d >= SYNC_BEG) && (pos_d < SYNC_END)) ? POL : ~POL;
  end

  // Position and sync level registers; both hold while en_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q  <= '0;
      sync_q <= ~POL;
    end else if (en_i) begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/display_timing.sv
// Raster timing generator: couples a horizontal and a vertical axis,
// presents (0,0) on the first enabled clock after reset, and produces
// data enable, line/frame start pulses and a 16-bit frame counter.
module display_timing
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_de,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [15:0] o_frame
);

  logic        first_q;
  logic        de_q, line_start_q, frame_start_q;
  logic [15:0] frame_q, frame_d;
  logic        line_start_d, frame_start_d;
  logic        h_last, v_last, h_act_nxt, v_act_nxt;
  logic        h_inc, v_inc, frame_wrap;

  // The first enabled clock after reset presents (0,0) without stepping.
  assign h_inc      = ~first_q;
  assign v_inc      = ~first_q & h_last;
  assign frame_wrap = ~first_q & h_last & v_last;

  timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
  ) u_h_axis (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .en_i         (i_pix_en),
    .inc_i        (h_inc),
    .pos_o        (o_x),
    .last_o       (h_last),
    .active_nxt_o (h_act_nxt),
    .sync_o       (o_h_sync)
  );

  timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
  ) u_v_axis (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .en_i         (i_pix_en),
    .inc_i        (v_inc),
    .pos_o        (o_y),
    .last_o       (v_last),
    .active_nxt_o (v_act_nxt),
    .sync_o       (o_v_sync)
  );

  // Pulses fire only on clocks that present a new position.
  always_comb begin
    line_start_d  = i_pix_en & (first_q | h_last);
    frame_start_d = i_pix_en & (first_q | (h_last & v_last));
    frame_d       = frame_q;
    if (i_pix_en && frame_wrap) begin
      frame_d = frame_q + 16'd1;
    end
  end

  // Control, data-enable, pulse and frame counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      first_q       <= 1'b1;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_q       <= '0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_q       <= frame_d;
      if (i_pix_en) begin
        first_q <= 1'b0;
        de_q    <= h_act_nxt & v_act_nxt;
      end
    end
  end

  assign o_de          = de_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_frame       = frame_q;

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing with reduced timing (H 8/2/3/2, V 4/1/2/1),
// one instance per sync polarity plus a 1x1 raster for frame wrap.
module tb_display_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, rst_t, en_t;

  logic [15:0] x0, y0, fr0, x1, y1, fr1, xt, yt, frt;
  logic de0, hs0, vs0, ls0, fs0;
  logic de1, hs1, vs1, ls1, fs1;
  logic det, hst, vst, lst, fst;

  display_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .H_POL(1'b0), .V_POL(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_pix_en(en), .o_x(x0), .o_y(y0),
    .o_h_sync(hs0), .o_v_sync(vs0), .o_de(de0), .o_line_start(ls0),
    .o_frame_start(fs0), .o_frame(fr0));

  display_timing #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .H_POL(1'b1), .V_POL(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_pix_en(en), .o_x(x1), .o_y(y1),
    .o_h_sync(hs1), .o_v_sync(vs1), .o_de(de1), .o_line_start(ls1),
    .o_frame_start(fs1), .o_frame(fr1));

  display_timing #(.H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
                   .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0)) dut_t (
    .i_clk(clk), .i_rst(rst_t), .i_pix_en(en_t), .o_x(xt), .o_y(yt),
    .o_h_sync(hst), .o_v_sync(vst), .o_de(det), .o_line_start(lst),
    .o_frame_start(fst), .o_frame(frt));

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] x;
    logic [15:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fr;
  } vec_t;

  vec_t vecs[21];
  int n_tests = 0;
  int n_fail  = 0;
  int ex, ey, efr;

  function automatic vec_t mk(input logic r, input logic e, input int x, input int y,
                              input logic de, input logic hs, input logic vs,
                              input logic ls, input logic fs, input int fr);
    vec_t v;
    v.rst = r; v.en = e; v.x = 16'(x); v.y = 16'(y);
    v.de = de; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs; v.fr = 16'(fr);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks both polarity instances against one set of POL=0 expectations.
  task automatic check_all(input string name, input logic [15:0] ex_x, input logic [15:0] ex_y,
                           input logic e_de, input logic e_hs, input logic e_vs,
                           input logic e_ls, input logic e_fs, input logic [15:0] e_fr);
    n_tests++;
    if ({x0, y0, de0, hs0, vs0, ls0, fs0, fr0} !== {ex_x, ex_y, e_de, e_hs, e_vs, e_ls, e_fs, e_fr}) begin
      n_fail++;
      $display("FAIL %s pol0: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fr=%0d, want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fr=%0d",
               name, x0, y0, de0, hs0, vs0, ls0, fs0, fr0, ex_x, ex_y, e_de, e_hs, e_vs, e_ls, e_fs, e_fr);
    end
    n_tests++;
    if ({x1, y1, de1, hs1, vs1, ls1, fs1, fr1} !== {ex_x, ex_y, e_de, ~e_hs, ~e_vs, e_ls, e_fs, e_fr}) begin
      n_fail++;
      $display("FAIL %s pol1: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fr=%0d, want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b fr=%0d",
               name, x1, y1, de1, hs1, vs1, ls1, fs1, fr1, ex_x, ex_y, e_de, ~e_hs, ~e_vs, e_ls, e_fs, e_fr);
    end
  endtask

  // Advances n enabled clocks, checking each presented position.
  task automatic run_enabled(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      ex++;
      if (ex == 15) begin
        ex = 0;
        ey++;
        if (ey == 8) begin
          ey = 0;
          efr++;
        end
      end
      step();
      check_all(name, 16'(ex), 16'(ey),
                (ex < 8) && (ey < 4),
                !((ex >= 10) && (ex <= 12)),
                !((ey >= 5) && (ey <= 6)),
                ex == 0, (ex == 0) && (ey == 0), 16'(efr));
    end
  endtask

  task automatic check_tiny(input string name, input logic e_fs, input logic [15:0] e_fr);
    n_tests++;
    if ({fst, frt} !== {e_fs, e_fr}) begin
      n_fail++;
      $display("FAIL %s: got fs=%b frame=%h, want fs=%b frame=%h", name, fst, frt, e_fs, e_fr);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rst_t = 1'b1; en_t = 1'b0;

    vecs[0]  = mk(1, 1,  0, 0, 0, 1, 1, 0, 0, 0);
    vecs[1]  = mk(1, 0,  0, 0, 0, 1, 1, 0, 0, 0);
    vecs[2]  = mk(0, 1,  0, 0, 1, 1, 1, 1, 1, 0);
    vecs[3]  = mk(0, 1,  1, 0, 1, 1, 1, 0, 0, 0);
    vecs[4]  = mk(0, 1,  2, 0, 1, 1, 1, 0, 0, 0);
    vecs[5]  = mk(0, 1,  3, 0, 1, 1, 1, 0, 0, 0);
    vecs[6]  = mk(0, 1,  4, 0, 1, 1, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0,  4, 0, 1, 1, 1, 0, 0, 0);
    vecs[8]  = mk(0, 0,  4, 0, 1, 1, 1, 0, 0, 0);
    vecs[9]  = mk(0, 1,  5, 0, 1, 1, 1, 0, 0, 0);
    vecs[10] = mk(0, 1,  6, 0, 1, 1, 1, 0, 0, 0);
    vecs[11] = mk(0, 1,  7, 0, 1, 1, 1, 0, 0, 0);
    vecs[12] = mk(0, 1,  8, 0, 0, 1, 1, 0, 0, 0);
    vecs[13] = mk(0, 1,  9, 0, 0, 1, 1, 0, 0, 0);
    vecs[14] = mk(0, 1, 10, 0, 0, 0, 1, 0, 0, 0);
    vecs[15] = mk(0, 1, 11, 0, 0, 0, 1, 0, 0, 0);
    vecs[16] = mk(0, 1, 12, 0, 0, 0, 1, 0, 0, 0);
    vecs[17] = mk(0, 1, 13, 0, 0, 1, 1, 0, 0, 0);
    vecs[18] = mk(0, 1, 14, 0, 0, 1, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 14, 0, 0, 1, 1, 0, 0, 0);
    vecs[20] = mk(0, 1,  0, 1, 1, 1, 1, 1, 0, 0);

    // Reset, first pixel, pixel-enable hold and horizontal decode.
    for (int i = 0; i < 21; i++) begin
      rst = vecs[i].rst;
      en  = vecs[i].en;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].de,
                vecs[i].hs, vecs[i].vs, vecs[i].ls, vecs[i].fs, vecs[i].fr);
    end

    // Full frame from reset through the (14,7)->(0,0) wrap.
    rst = 1'b1; en = 1'b1;
    step();
    check_all("frame_rst", 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    step();
    check_all("frame_first", 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0);
    ex = 0; ey = 0; efr = 0;
    run_enabled("frame_run", 120);
    check_all("frame_wrap", 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1);

    // Mid-frame reset at (6,2) with pixel enable still high.
    run_enabled("to_6_2", 36);
    check_all("at_6_2", 16'd6, 16'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
    rst = 1'b1; en = 1'b1;
    step();
    check_all("mid_rst", 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    rst = 1'b0; en = 1'b0;
    step();
    check_all("rst_idle", 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    en = 1'b1;
    step();
    check_all("rst_first", 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0);
    en = 1'b0;

    // Frame counter rollover on a 1x1 raster: every enabled clock wraps.
    rst_t = 1'b1; en_t = 1'b1;
    step();
    check_tiny("tiny_rst", 1'b0, 16'h0000);
    rst_t = 1'b0;
    step();
    check_tiny("tiny_first", 1'b1, 16'h0000);
    repeat (65535) step();
    check_tiny("tiny_ffff", 1'b1, 16'hFFFF);
    step();
    check_tiny("tiny_roll", 1'b1, 16'h0000);
    en_t = 1'b0;
    step();
    check_tiny("tiny_hold", 1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_timing.md
DISPLAY_TIMING -- requirements
Module: display_timing

Interface
REQ-001 Parameters (name, default, meaning):
  H_ACTIVE 640 visible pixels per line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch;
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; H_POL 0 / V_POL 0 sync active level (0 = active-low).
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Ports (name direction width meaning):
  i_clk input 1 system/pixel clock.
  i_rst input 1 synchronous active-high reset.
  i_pix_en input 1 pixel-advance strobe (tie high for one pixel per clock).
  o_x output 16 horizontal position, 0..H_TOTAL-1.
  o_y output 16 vertical position, 0..V_TOTAL-1.
  o_h_sync output 1 horizontal sync at H_POL level.
  o_v_sync output 1 vertical sync at V_POL level; feeds the compositor i_v_sync.
  o_de output 1 data enable; high inside the visible area.
  o_line_start output 1 one-clock pulse when x becomes 0.
  o_frame_start output 1 one-clock pulse when (x,y) becomes (0,0).
  o_frame output 16 frame counter.

Function
REQ-004 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; both SHALL be elaboration-time constants ≤ 65535.
REQ-005 Line layout: active x 0..H_ACTIVE-1, front porch, sync x H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1, back porch; vertical layout identical on y.
REQ-006 Each clock with i_pix_en=1 advances the position one step: x+1; at x=H_TOTAL-1, x wraps to 0 and y+1; at y=V_TOTAL-1 with x wrap, y wraps to 0.
REQ-007 With i_pix_en=0, all outputs hold their values; pulses are deasserted.
REQ-008 All outputs are registered and mutually coherent: o_h_sync, o_v_sync, o_de and the pulses always decode the (o_x,o_y) presented in the same cycle.
REQ-009 o_de = (o_x < H_ACTIVE) and (o_y < V_ACTIVE).
REQ-010 o_v_sync is asserted for every x on the sync lines, not just from x=0.
REQ-011 o_line_start is high for exactly one clock in each cycle that presents a new position with x=0; o_frame_start likewise for (0,0).
REQ-012 o_frame increments by 1, modulo 2^16 (0xFFFF→0x0000), on every wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0); o_frame is 0 during the first frame after reset.

Reset
REQ-013 While i_rst=1: o_x=0, o_y=0, o_de=0, o_h_sync=!H_POL, o_v_sync=!V_POL, o_line_start=0, o_frame_start=0, o_frame=0.
REQ-014 The first i_pix_en=1 cycle after i_rst falls presents (0,0) with o_de=1, o_line_start=1, o_frame_start=1; each subsequent advance follows REQ-006.
REQ-015 i_rst asserted mid-frame returns all outputs to REQ-013 values on the next clock, regardless of i_pix_en.
REQ-016 i_rst takes precedence over i_pix_en in the same cycle.

Structure
REQ-017 A shared package holds the default timing constants (640x480@60) and a derived H_TOTAL/V_TOTAL function; the gfx-side blocks import the same constants for H_ACTIVE/V_ACTIVE.
REQ-018 One sub-module, timing_axis, is instantiated twice (horizontal, vertical): a wrap counter with an enable, a wrap flag, and active/sync decode; the top adds coupling, the first-pixel flag, pulses and the frame counter.

Verification (reduced params H 8/2/3/2 → H_TOTAL 15; V 4/1/2/1 → V_TOTAL 8; POL 0)
REQ-019 Reset, then i_pix_en=1 constant → cycle 1: (0,0), de=1, line_start=1, frame_start=1; x=7 de=1; x=8 de=0; h_sync low exactly for x=10..12.
REQ-020 Run 120 enabled clocks → (14,7)→(0,0) wrap, frame_start=1, o_frame=1; v_sync low for all x with y=5..6; de=0 for y≥4.
REQ-021 i_pix_en toggled 1,0,0,1 at (3,0) → outputs hold (4,0) for two clocks, then present (5,0); no pulse repeats.
REQ-022 o_frame preloaded by running 65536 frames (or forced to 0xFFFF) → next wrap gives o_frame=0x0000.
REQ-023 i_rst pulsed at (6,2) with i_pix_en=1 → next clock shows REQ-013 values; the first enabled clock after release shows (0,0) with frame_start=1.
REQ-024 H_POL=1, V_POL=1 rerun of REQ-019/020 → sync levels inverted, all positions unchanged.
